// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register; flush beats stall, a bubble clears every field
module if_id_register
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instruction;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= 32'h0;
            r_valid       <= 1'b0;
        end else if (i_flush) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= 32'h0;
            r_valid       <= 1'b0;
        end else if (!i_stall) begin
            r_instruction <= i_instruction;
            r_pc_plus4    <= i_pc_plus4;
            r_valid       <= i_valid;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, BOOT/RUN/HALT FSM and fetch counter feeding the IF/ID register
// Optional build macro: BRANCH_DELAY_SLOT_EN (keep the word fetched alongside a taken branch)
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;
    logic         r_halted;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect;
    logic         w_in_run;
    logic         w_branch_squash;
    logic         w_squash;
    logic         w_capture;
    logic         w_halt_hit;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = BranchTarget & ~32'h3;
    assign w_in_run   = (r_state == ST_RUN);
    assign w_halt_hit = (Instruction == HALT_WORD);

`ifdef BRANCH_DELAY_SLOT_EN
    assign w_branch_squash = 1'b0;
`else
    assign w_branch_squash = BranchTaken;
`endif

    assign w_squash  = Flush | w_branch_squash;
    assign w_capture = w_in_run & ~w_squash & ~Stall;

    // A taken branch redirects even under stall so the redirect cannot be lost.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'h0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (BranchTaken)
                        r_pc <= w_redirect;
                    else if (!Stall)
                        r_pc <= w_pc_plus4;
                    if (w_capture) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        if (w_halt_hit) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_HALT: r_halted <= 1'b1;
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    if_id_register u_if_id (
        .i_clk         (Clk),
        .i_rst_n       (Rst),
        .i_stall       (Stall),
        .i_flush       (~w_in_run | w_squash),
        .i_instruction (Instruction),
        .i_pc_plus4    (w_pc_plus4),
        .i_valid       (1'b1),
        .o_instruction (IF_ID_Instruction),
        .o_pc_plus4    (IF_ID_PCPlus4),
        .o_valid       (IF_ID_Valid)
    );

    assign Address    = r_pc;
    assign Halted     = r_halted;
    assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] Address;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'h0;
    exp_t        sb[$];
    exp_t        e;

    instruction_fetch_unit dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Stall             (Stall),
        .Flush             (Flush),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .Instruction       (Instruction),
        .Address           (Address),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Halted            (Halted),
        .FetchCount        (FetchCount)
    );

    always #5 Clk = ~Clk;

    // Memory model: high half is the inverse of the low half, so never the halt word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign Instruction = (halt_en && Address == halt_addr) ? HALT_W : mem_word(Address);

    function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid,
                                input logic halted, input logic [31:0] count);
        exp_t x;
        x = '{addr: addr, instr: instr, pc4: pc4, valid: valid, halted: halted, count: count};
        return x;
    endfunction

    function automatic exp_t snap();
        return mk(Address, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, Halted, FetchCount);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", snap(), e);
        end
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        tick();
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL reset_held_over_edge got=%h want=%h", snap(), e);
        end
        exp_count = 32'h0;
    endtask

    task automatic test_sequential();
        Rst = 1'b1;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        for (int i = 0; i < 2; i++) begin
            exp_count++;
            sb.push_back(mk(32'd4 * (i + 1), mem_word(32'd4 * i), 32'd4 * (i + 1), 1'b1, 1'b0, exp_count));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL seq_fetch_%0d got=%h want=%h", i, snap(), e);
            end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(32'h8, mem_word(32'h4), 32'h8, 1'b1, 1'b0, exp_count));
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL stall_hold_%0d got=%h want=%h", i, snap(), e);
            end
        end
        Stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_count++;
            sb.push_back(mk(32'd12 + 32'd4 * i, mem_word(32'd8 + 32'd4 * i), 32'd12 + 32'd4 * i,
                            1'b1, 1'b0, exp_count));
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL stall_resume_%0d got=%h want=%h", i, snap(), e);
            end
        end
    endtask

    task automatic test_branch();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0043;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_count++;
        sb.push_back(mk(32'h40, mem_word(32'h10), 32'h14, 1'b1, 1'b0, exp_count));
`else
        sb.push_back(mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, exp_count));
`endif
        tick();
        BranchTaken = 1'b0;
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL branch_redirect got=%h want=%h", snap(), e);
        end
        exp_count++;
        sb.push_back(mk(32'h44, mem_word(32'h40), 32'h44, 1'b1, 1'b0, exp_count));
        tick();
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL branch_target_fetch got=%h want=%h", snap(), e);
        end
    endtask

    task automatic test_stall_flush_branch();
        Stall        = 1'b1;
        Flush        = 1'b1;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0100;
        sb.push_back(mk(32'h100, 32'h0, 32'h0, 1'b0, 1'b0, exp_count));
        tick();
        Stall       = 1'b0;
        Flush       = 1'b0;
        BranchTaken = 1'b0;
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL combo_redirect_bubble got=%h want=%h", snap(), e);
        end
        exp_count++;
        sb.push_back(mk(32'h104, mem_word(32'h100), 32'h104, 1'b1, 1'b0, exp_count));
        tick();
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL combo_resume got=%h want=%h", snap(), e);
        end
    endtask

    task automatic test_halt_wrap();
        halt_en      = 1'b1;
        halt_addr    = 32'hFFFF_FFFC;
        BranchTaken  = 1'b1;
        BranchTarget = 32'hFFFF_FFFF;
`ifdef BRANCH_DELAY_SLOT_EN
        exp_count++;
        sb.push_back(mk(32'hFFFF_FFFC, mem_word(32'h104), 32'h108, 1'b1, 1'b0, exp_count));
`else
        sb.push_back(mk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, exp_count));
`endif
        tick();
        BranchTaken = 1'b0;
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL halt_branch_to_top got=%h want=%h", snap(), e);
        end
        exp_count++;
        sb.push_back(mk(32'h0, HALT_W, 32'h0, 1'b1, 1'b1, exp_count));
        tick();
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL halt_capture_wrap got=%h want=%h", snap(), e);
        end
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, exp_count));
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL halt_frozen_%0d got=%h want=%h", i, snap(), e);
            end
        end
        BranchTaken = 1'b0;
        halt_en     = 1'b0;
    endtask

    task automatic test_async_reset();
        Rst = 1'b0;
        #1;
        exp_count = 32'h0;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL async_reset_from_halt got=%h want=%h", snap(), e);
        end
        tick();
        Rst = 1'b1;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        exp_count++;
        sb.push_back(mk(32'h4, mem_word(32'h0), 32'h4, 1'b1, 1'b0, exp_count));
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL async_restart_%0d got=%h want=%h", i, snap(), e);
            end
        end
        BranchTaken  = 1'b1;
        BranchTarget = 32'h0000_0200;
        #3;
        Rst = 1'b0;
        #1;
        exp_count = 32'h0;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        e = sb.pop_front();
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL async_reset_midcycle got=%h want=%h", snap(), e);
        end
        tick();
        Rst         = 1'b1;
        BranchTaken = 1'b0;
        sb.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        exp_count++;
        sb.push_back(mk(32'h4, mem_word(32'h0), 32'h4, 1'b1, 1'b0, exp_count));
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL async_reboot_%0d got=%h want=%h", i, snap(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_stall_flush_branch();
        test_halt_wrap();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
